// File: rtl/pub_domain_tracker.sv
// pub_domain_tracker
//   Tracks shared buffers by base address between the DMem port arbiters
//   and the address-config units. A store claims an entry (first-free
//   allocation), fills it, then publishes it with a reader count. Loads of
//   that base consume it, and the last reader frees the entry.
//
// Ports
//   clock, reset        clock; synchronous active-high reset
//   I_Stall             freezes FSMs, table and edge detection
//   I_St_Grant/Base/NumRd/End   store channel grant levels, base, readers, end pulse
//   I_Ld_Grant/Base/End         load channel grant levels, base, end pulse
//   O_St_Ready/O_Ld_Ready       ready to the latched granted channel while BUSY
//   O_St_Full           store waiting because every entry is valid
//   O_Set_Config_St/Ld  one-cycle pulse on entering BUSY
//   O_Num_Valid         number of valid entries
//   O_Err               sticky protocol error
//
// Handshake: a transaction starts on a rising edge of a grant bit. Ready is a
// level to that channel for the whole BUSY phase. The transfer finishes on a
// one-cycle End pulse while Ready is high. Dropping the grant before End aborts.
module pub_domain_tracker #(
  parameter int NUM_ENTRY   = 32,
  parameter int NUM_ST_PORT = 3,
  parameter int NUM_LD_PORT = 3,
  parameter int WIDTH_ADDR  = 32,
  parameter int WIDTH_RCNT  = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           I_Stall,
  input  logic [NUM_ST_PORT-1:0]         I_St_Grant,
  input  logic [WIDTH_ADDR-1:0]          I_St_Base,
  input  logic [WIDTH_RCNT-1:0]          I_St_NumRd,
  input  logic                           I_St_End,
  input  logic [NUM_LD_PORT-1:0]         I_Ld_Grant,
  input  logic [WIDTH_ADDR-1:0]          I_Ld_Base,
  input  logic                           I_Ld_End,
  output logic [NUM_ST_PORT-1:0]         O_St_Ready,
  output logic [NUM_LD_PORT-1:0]         O_Ld_Ready,
  output logic                           O_St_Full,
  output logic                           O_Set_Config_St,
  output logic                           O_Set_Config_Ld,
  output logic [$clog2(NUM_ENTRY+1)-1:0] O_Num_Valid,
  output logic                           O_Err
);

  localparam int EW = $clog2(NUM_ENTRY);
  localparam int CW = $clog2(NUM_ENTRY+1);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WAIT, S_BUSY} state_t;

  // Entry table
  logic [NUM_ENTRY-1:0]  ent_valid, ent_stored;
  logic [WIDTH_RCNT-1:0] ent_rcnt [NUM_ENTRY];
  logic [WIDTH_ADDR-1:0] ent_base [NUM_ENTRY];

  // FSM state and per-transaction registers
  state_t                 st_state, st_next, ld_state, ld_next;
  logic [NUM_ST_PORT-1:0] st_gnt_prev, st_gnt_q, st_rise;
  logic [NUM_LD_PORT-1:0] ld_gnt_prev, ld_gnt_q, ld_rise;
  logic [WIDTH_ADDR-1:0]  st_base_q, ld_base_q;
  logic [EW-1:0]          st_ent_q, ld_ent_q, free_idx, ld_hit_idx;
  logic                   st_full_q, cfg_st_q, cfg_ld_q, err_q;

  // Combinational decisions
  logic                  st_live, ld_live, st_hit, free_any, ld_hit;
  logic                  st_alloc, st_commit, st_abort, st_full_next, ld_release;
  logic                  err_set;
  logic [WIDTH_RCNT-1:0] st_rcnt_init;

  assign st_rise = I_St_Grant & ~st_gnt_prev;
  assign ld_rise = I_Ld_Grant & ~ld_gnt_prev;
  assign st_live = |(I_St_Grant & st_gnt_q);
  assign ld_live = |(I_Ld_Grant & ld_gnt_q);
  assign st_rcnt_init = (I_St_NumRd == '0) ? WIDTH_RCNT'(1) : I_St_NumRd;

  // Lookups see the registered table, so a same-cycle free is not yet
  // visible to an allocation and a same-cycle release still looks like a hit.
  always_comb begin
    st_hit     = 1'b0;
    free_any   = 1'b0;
    free_idx   = '0;
    ld_hit     = 1'b0;
    ld_hit_idx = '0;
    // Descending scan so the last assignment is the lowest index.
    for (int i = NUM_ENTRY-1; i >= 0; i--) begin
      if (ent_valid[i] && ent_base[i] == st_base_q) st_hit = 1'b1;
      if (!ent_valid[i]) begin
        free_any = 1'b1;
        free_idx = EW'(i);
      end
      if (ent_valid[i] && ent_stored[i] && ent_base[i] == ld_base_q) begin
        ld_hit     = 1'b1;
        ld_hit_idx = EW'(i);
      end
    end
  end

  // Store FSM next state
  always_comb begin
    st_next      = st_state;
    st_alloc     = 1'b0;
    st_commit    = 1'b0;
    st_abort     = 1'b0;
    st_full_next = 1'b0;
    case (st_state)
      S_IDLE:   if (|st_rise) st_next = S_LOOKUP;
      S_LOOKUP,
      S_WAIT: begin
        if (!st_live) st_next = S_IDLE;
        // Any hit means the base is either being filled by another store
        // or still has readers pending.
        else if (st_hit) st_next = S_WAIT;
        else if (free_any) begin
          st_alloc = 1'b1;
          st_next  = S_BUSY;
        end else begin
          st_next      = S_WAIT;
          st_full_next = 1'b1;
        end
      end
      S_BUSY: begin
        if (I_St_End) begin
          st_commit = 1'b1;
          st_next   = S_IDLE;
        end else if (!st_live) begin
          st_abort = 1'b1;
          st_next  = S_IDLE;
        end
      end
      default: st_next = S_IDLE;
    endcase
  end

  // Load FSM next state
  always_comb begin
    ld_next    = ld_state;
    ld_release = 1'b0;
    case (ld_state)
      S_IDLE:   if (|ld_rise) ld_next = S_LOOKUP;
      S_LOOKUP,
      S_WAIT: begin
        if (!ld_live) ld_next = S_IDLE;
        else if (ld_hit) ld_next = S_BUSY;
        else ld_next = S_WAIT;
      end
      S_BUSY: begin
        if (I_Ld_End) begin
          ld_release = 1'b1;
          ld_next    = S_IDLE;
        end else if (!ld_live) ld_next = S_IDLE;
      end
      default: ld_next = S_IDLE;
    endcase
  end

  assign err_set = ((I_St_Grant & (I_St_Grant - NUM_ST_PORT'(1))) != '0)
                 | ((I_Ld_Grant & (I_Ld_Grant - NUM_LD_PORT'(1))) != '0)
                 | (I_St_End && st_state != S_BUSY)
                 | (I_Ld_End && ld_state != S_BUSY);

  // Control registers
  always_ff @(posedge clock) begin
    if (reset) begin
      st_state    <= S_IDLE;
      ld_state    <= S_IDLE;
      st_gnt_prev <= '0;
      ld_gnt_prev <= '0;
      st_gnt_q    <= '0;
      ld_gnt_q    <= '0;
      st_base_q   <= '0;
      ld_base_q   <= '0;
      st_ent_q    <= '0;
      ld_ent_q    <= '0;
      st_full_q   <= 1'b0;
      cfg_st_q    <= 1'b0;
      cfg_ld_q    <= 1'b0;
      err_q       <= 1'b0;
    end else if (!I_Stall) begin
      st_state    <= st_next;
      ld_state    <= ld_next;
      st_gnt_prev <= I_St_Grant;
      ld_gnt_prev <= I_Ld_Grant;
      if (st_state == S_IDLE && |st_rise) begin
        st_gnt_q  <= st_rise;
        st_base_q <= I_St_Base;
      end
      if (ld_state == S_IDLE && |ld_rise) begin
        ld_gnt_q  <= ld_rise;
        ld_base_q <= I_Ld_Base;
      end
      if (st_alloc) st_ent_q <= free_idx;
      if (ld_state != S_BUSY && ld_next == S_BUSY) ld_ent_q <= ld_hit_idx;
      st_full_q <= st_full_next;
      cfg_st_q  <= (st_next == S_BUSY) && (st_state != S_BUSY);
      cfg_ld_q  <= (ld_next == S_BUSY) && (ld_state != S_BUSY);
      err_q     <= err_q | err_set;
    end
  end

  // Entry table. Store and load updates always target different entries:
  // a load can only be BUSY on a stored entry, a store only on an unstored one.
  always_ff @(posedge clock) begin
    if (reset) begin
      ent_valid  <= '0;
      ent_stored <= '0;
      for (int i = 0; i < NUM_ENTRY; i++) begin
        ent_rcnt[i] <= '0;
        ent_base[i] <= '0;
      end
    end else if (!I_Stall) begin
      if (st_alloc) begin
        ent_valid[free_idx]  <= 1'b1;
        ent_stored[free_idx] <= 1'b0;
        ent_rcnt[free_idx]   <= '0;
        ent_base[free_idx]   <= st_base_q;
      end
      if (st_commit) begin
        ent_stored[st_ent_q] <= 1'b1;
        ent_rcnt[st_ent_q]   <= st_rcnt_init;
      end
      if (st_abort) begin
        ent_valid[st_ent_q]  <= 1'b0;
        ent_stored[st_ent_q] <= 1'b0;
      end
      if (ld_release) begin
        if (ent_rcnt[ld_ent_q] <= WIDTH_RCNT'(1)) begin
          ent_valid[ld_ent_q]  <= 1'b0;
          ent_stored[ld_ent_q] <= 1'b0;
          ent_rcnt[ld_ent_q]   <= '0;
        end else begin
          ent_rcnt[ld_ent_q] <= ent_rcnt[ld_ent_q] - WIDTH_RCNT'(1);
        end
      end
    end
  end

  assign O_St_Ready      = (st_state == S_BUSY) ? st_gnt_q : '0;
  assign O_Ld_Ready      = (ld_state == S_BUSY) ? ld_gnt_q : '0;
  assign O_St_Full       = st_full_q;
  assign O_Set_Config_St = cfg_st_q;
  assign O_Set_Config_Ld = cfg_ld_q;
  assign O_Num_Valid     = CW'($countones(ent_valid));
  assign O_Err           = err_q;

endmodule

// File: tb/tb_pub_domain_tracker.sv
// Testbench for pub_domain_tracker (default parameters: 32 entries, 3+3 ports).
module tb_pub_domain_tracker;
  localparam int NS  = 3;
  localparam int NL  = 3;
  localparam int CW  = 6;
  localparam int SBW = 4;  // {is_load, ready vector}

  logic          clock = 1'b0;
  logic          reset;
  logic          I_Stall;
  logic [NS-1:0] I_St_Grant;
  logic [31:0]   I_St_Base;
  logic [3:0]    I_St_NumRd;
  logic          I_St_End;
  logic [NL-1:0] I_Ld_Grant;
  logic [31:0]   I_Ld_Base;
  logic          I_Ld_End;
  logic [NS-1:0] O_St_Ready;
  logic [NL-1:0] O_Ld_Ready;
  logic          O_St_Full, O_Set_Config_St, O_Set_Config_Ld, O_Err;
  logic [CW-1:0] O_Num_Valid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [SBW-1:0] exp_q[$];
  logic [SBW-1:0] got, want;

  pub_domain_tracker dut (
    .clock(clock), .reset(reset), .I_Stall(I_Stall),
    .I_St_Grant(I_St_Grant), .I_St_Base(I_St_Base), .I_St_NumRd(I_St_NumRd), .I_St_End(I_St_End),
    .I_Ld_Grant(I_Ld_Grant), .I_Ld_Base(I_Ld_Base), .I_Ld_End(I_Ld_End),
    .O_St_Ready(O_St_Ready), .O_Ld_Ready(O_Ld_Ready), .O_St_Full(O_St_Full),
    .O_Set_Config_St(O_Set_Config_St), .O_Set_Config_Ld(O_Set_Config_Ld),
    .O_Num_Valid(O_Num_Valid), .O_Err(O_Err)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; I_Stall = 1'b0;
    I_St_Grant = '0; I_St_Base = '0; I_St_NumRd = '0; I_St_End = 1'b0;
    I_Ld_Grant = '0; I_Ld_Base = '0; I_Ld_End = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Drivers
  task automatic st_drive(input int port, input logic [31:0] base, input logic [3:0] nrd);
    I_St_Grant = NS'(1) << port; I_St_Base = base; I_St_NumRd = nrd;
  endtask

  task automatic ld_drive(input int port, input logic [31:0] base);
    I_Ld_Grant = NL'(1) << port; I_Ld_Base = base;
  endtask

  task automatic st_end_pulse();
    I_St_End = 1'b1; tick(); I_St_End = 1'b0;
  endtask

  task automatic ld_end_pulse();
    I_Ld_End = 1'b1; tick(); I_Ld_End = 1'b0;
  endtask

  // Complete store transaction used for setup only.
  task automatic st_cycle(input int port, input logic [31:0] base, input logic [3:0] nrd);
    st_drive(port, base, nrd);
    tick(); tick();
    st_end_pulse();
    I_St_Grant = '0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({O_St_Ready, O_Ld_Ready, O_St_Full, O_Set_Config_St, O_Set_Config_Ld, O_Num_Valid, O_Err} !== 16'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0000",
        {O_St_Ready, O_Ld_Ready, O_St_Full, O_Set_Config_St, O_Set_Config_Ld, O_Num_Valid, O_Err});
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if ({O_St_Ready, O_Ld_Ready, O_Num_Valid, O_Err} !== 13'h0) begin
      n_fail++; $display("FAIL post_reset_idle: got %h want 0000", {O_St_Ready, O_Ld_Ready, O_Num_Valid, O_Err});
    end
  endtask

  task automatic test_store_basic();
    st_drive(0, 32'h100, 4'd2);
    exp_q.push_back({1'b0, 3'b001});
    tick();
    n_checks++;
    if (O_St_Ready !== 3'b000) begin n_fail++; $display("FAIL st_ready_t1: got %b want 000", O_St_Ready); end
    tick();
    got = {1'b0, O_St_Ready}; want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL st_ready_t2: got %b want %b", got, want); end
    n_checks++;
    if (O_Set_Config_St !== 1'b1) begin n_fail++; $display("FAIL st_cfg_pulse: got %b want 1", O_Set_Config_St); end
    n_checks++;
    if (O_Num_Valid !== 6'd1) begin n_fail++; $display("FAIL st_num_valid: got %0d want 1", O_Num_Valid); end
    st_end_pulse();
    n_checks++;
    if ({O_St_Ready, O_Set_Config_St} !== 4'b0000) begin
      n_fail++; $display("FAIL st_after_end: got %b want 0000", {O_St_Ready, O_Set_Config_St});
    end
    I_St_Grant = '0;
    tick();
  endtask

  task automatic test_two_loads();
    logic [CW-1:0] exp_nv;
    for (int k = 0; k < 2; k++) begin
      ld_drive(k + 1, 32'h100);
      exp_q.push_back({1'b1, NL'(1) << (k + 1)});
      tick(); tick();
      got = {1'b1, O_Ld_Ready}; want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL ld_ready_%0d: got %b want %b", k, got, want); end
      n_checks++;
      if (O_Set_Config_Ld !== 1'b1) begin n_fail++; $display("FAIL ld_cfg_%0d: got %b want 1", k, O_Set_Config_Ld); end
      ld_end_pulse();
      exp_nv = (k == 0) ? 6'd1 : 6'd0;
      n_checks++;
      if (O_Num_Valid !== exp_nv) begin n_fail++; $display("FAIL ld_release_%0d: got %0d want %0d", k, O_Num_Valid, exp_nv); end
      I_Ld_Grant = '0;
      tick();
    end
  endtask

  task automatic test_load_before_store();
    ld_drive(0, 32'h200);
    repeat (4) tick();
    n_checks++;
    if (O_Ld_Ready !== 3'b000) begin n_fail++; $display("FAIL early_ld_wait: got %b want 000", O_Ld_Ready); end
    st_drive(1, 32'h200, 4'd1);
    exp_q.push_back({1'b0, 3'b010});
    tick(); tick();
    got = {1'b0, O_St_Ready}; want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL st200_ready: got %b want %b", got, want); end
    st_end_pulse();
    n_checks++;
    if (O_Ld_Ready !== 3'b000) begin n_fail++; $display("FAIL ld_at_commit: got %b want 000", O_Ld_Ready); end
    exp_q.push_back({1'b1, 3'b001});
    tick();
    got = {1'b1, O_Ld_Ready}; want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL ld_after_commit: got %b want %b", got, want); end
    ld_end_pulse();
    n_checks++;
    if (O_Num_Valid !== 6'd0) begin n_fail++; $display("FAIL ld200_free: got %0d want 0", O_Num_Valid); end
    I_St_Grant = '0; I_Ld_Grant = '0;
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 32; i++) st_cycle(i % 3, 32'h1000 + 32'(i) * 32'h10, 4'd1);
    n_checks++;
    if (O_Num_Valid !== 6'd32) begin n_fail++; $display("FAIL fill_count: got %0d want 32", O_Num_Valid); end
    st_drive(0, 32'h9000, 4'd1);
    tick(); tick();
    n_checks++;
    if ({O_St_Full, O_St_Ready} !== 4'b1000) begin
      n_fail++; $display("FAIL full_wait: got %b want 1000", {O_St_Full, O_St_Ready});
    end
    ld_drive(1, 32'h1050);
    exp_q.push_back({1'b1, 3'b010});
    tick(); tick();
    got = {1'b1, O_Ld_Ready}; want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL full_ld_ready: got %b want %b", got, want); end
    ld_end_pulse();
    n_checks++;
    if ({O_St_Full, O_Num_Valid} !== {1'b1, 6'd31}) begin
      n_fail++; $display("FAIL full_release: got full=%b nv=%0d want full=1 nv=31", O_St_Full, O_Num_Valid);
    end
    exp_q.push_back({1'b0, 3'b001});
    tick();
    got = {1'b0, O_St_Ready}; want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL full_alloc_ready: got %b want %b", got, want); end
    n_checks++;
    if ({O_St_Full, O_Num_Valid} !== {1'b0, 6'd32}) begin
      n_fail++; $display("FAIL full_drop: got full=%b nv=%0d want full=0 nv=32", O_St_Full, O_Num_Valid);
    end
    n_checks++;
    if (dut.ent_base[5] !== 32'h9000) begin n_fail++; $display("FAIL full_alloc_idx: got %h want 00009000", dut.ent_base[5]); end
    st_end_pulse();
    I_St_Grant = '0; I_Ld_Grant = '0;
    tick();
  endtask

  task automatic test_restore_blocked();
    apply_reset();
    st_cycle(0, 32'h100, 4'd2);
    st_drive(2, 32'h100, 4'd1);
    tick(); tick(); tick();
    n_checks++;
    if ({O_St_Full, O_St_Ready} !== 4'b0000) begin
      n_fail++; $display("FAIL restore_wait: got %b want 0000", {O_St_Full, O_St_Ready});
    end
    ld_drive(0, 32'h100);
    tick(); tick();
    n_checks++;
    if (O_Ld_Ready !== 3'b001) begin n_fail++; $display("FAIL restore_ld0: got %b want 001", O_Ld_Ready); end
    ld_end_pulse();
    I_Ld_Grant = '0;
    tick();
    ld_drive(1, 32'h100);
    tick(); tick();
    n_checks++;
    if (O_Ld_Ready !== 3'b010) begin n_fail++; $display("FAIL restore_ld1: got %b want 010", O_Ld_Ready); end
    ld_end_pulse();
    n_checks++;
    if (O_St_Ready !== 3'b000) begin n_fail++; $display("FAIL restore_same_cycle: got %b want 000", O_St_Ready); end
    I_Ld_Grant = '0;
    exp_q.push_back({1'b0, 3'b100});
    tick();
    got = {1'b0, O_St_Ready}; want = exp_q.pop_front();
    n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL restore_busy: got %b want %b", got, want); end
    st_end_pulse();
    I_St_Grant = '0;
    tick();
    n_checks++;
    if (O_Num_Valid !== 6'd1) begin n_fail++; $display("FAIL restore_count: got %0d want 1", O_Num_Valid); end
  endtask

  task automatic test_abort();
    apply_reset();
    st_drive(0, 32'h300, 4'd1);
    tick(); tick();
    n_checks++;
    if ({O_St_Ready, O_Num_Valid} !== {3'b001, 6'd1}) begin
      n_fail++; $display("FAIL abort_busy: got rdy=%b nv=%0d want rdy=001 nv=1", O_St_Ready, O_Num_Valid);
    end
    I_St_Grant = '0;
    tick();
    n_checks++;
    if ({O_St_Ready, O_Num_Valid} !== 9'h0) begin
      n_fail++; $display("FAIL abort_free: got rdy=%b nv=%0d want rdy=000 nv=0", O_St_Ready, O_Num_Valid);
    end
    st_drive(1, 32'h310, 4'd1);
    tick(); tick();
    n_checks++;
    if (O_St_Ready !== 3'b010) begin n_fail++; $display("FAIL midreset_busy: got %b want 010", O_St_Ready); end
    reset = 1'b1; I_St_Grant = '0;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({O_St_Ready, O_Ld_Ready, O_St_Full, O_Set_Config_St, O_Set_Config_Ld, O_Num_Valid, O_Err} !== 16'h0) begin
      n_fail++; $display("FAIL midreset_outputs: got %h want 0000",
        {O_St_Ready, O_Ld_Ready, O_St_Full, O_Set_Config_St, O_Set_Config_Ld, O_Num_Valid, O_Err});
    end
    tick(); tick();
    n_checks++;
    if ({O_St_Ready, O_Num_Valid} !== 9'h0) begin
      n_fail++; $display("FAIL midreset_after: got rdy=%b nv=%0d want 0", O_St_Ready, O_Num_Valid);
    end
    st_cycle(0, 32'h400, 4'd1);
    ld_drive(2, 32'h400);
    tick(); tick();
    n_checks++;
    if (O_Ld_Ready !== 3'b100) begin n_fail++; $display("FAIL ldabort_busy: got %b want 100", O_Ld_Ready); end
    I_Ld_Grant = '0;
    tick();
    n_checks++;
    if ({O_Ld_Ready, O_Num_Valid} !== {3'b000, 6'd1}) begin
      n_fail++; $display("FAIL ldabort_idle: got rdy=%b nv=%0d want rdy=000 nv=1", O_Ld_Ready, O_Num_Valid);
    end
    ld_drive(0, 32'h400);
    tick(); tick();
    n_checks++;
    if (O_Ld_Ready !== 3'b001) begin n_fail++; $display("FAIL ldabort_retry: got %b want 001", O_Ld_Ready); end
    ld_end_pulse();
    n_checks++;
    if (O_Num_Valid !== 6'd0) begin n_fail++; $display("FAIL ldabort_free: got %0d want 0", O_Num_Valid); end
    I_Ld_Grant = '0;
    tick();
  endtask

  task automatic test_stall();
    apply_reset();
    st_drive(0, 32'h500, 4'd1);
    I_Stall = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({O_St_Ready, O_Num_Valid} !== 9'h0) begin
      n_fail++; $display("FAIL stall_frozen: got rdy=%b nv=%0d want 0", O_St_Ready, O_Num_Valid);
    end
    I_Stall = 1'b0;
    tick();
    n_checks++;
    if (O_St_Ready !== 3'b000) begin n_fail++; $display("FAIL stall_resume_t1: got %b want 000", O_St_Ready); end
    tick();
    n_checks++;
    if (O_St_Ready !== 3'b001) begin n_fail++; $display("FAIL stall_resume_t2: got %b want 001", O_St_Ready); end
    I_Stall = 1'b1; I_St_End = 1'b1;
    tick();
    I_St_End = 1'b0;
    tick();
    n_checks++;
    if ({O_St_Ready, O_Err} !== 4'b0010) begin
      n_fail++; $display("FAIL stall_busy_hold: got %b want 0010", {O_St_Ready, O_Err});
    end
    I_Stall = 1'b0;
    st_end_pulse();
    n_checks++;
    if ({O_St_Ready, O_Num_Valid} !== {3'b000, 6'd1}) begin
      n_fail++; $display("FAIL stall_commit: got rdy=%b nv=%0d want rdy=000 nv=1", O_St_Ready, O_Num_Valid);
    end
    I_St_Grant = '0;
    tick();
  endtask

  task automatic test_err();
    apply_reset();
    ld_end_pulse();
    n_checks++;
    if (O_Err !== 1'b1) begin n_fail++; $display("FAIL err_end_idle: got %b want 1", O_Err); end
    tick();
    n_checks++;
    if (O_Err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", O_Err); end
    apply_reset();
    n_checks++;
    if (O_Err !== 1'b0) begin n_fail++; $display("FAIL err_reset: got %b want 0", O_Err); end
    I_St_Grant = 3'b011;
    tick();
    n_checks++;
    if (O_Err !== 1'b1) begin n_fail++; $display("FAIL err_multihot: got %b want 1", O_Err); end
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_store_basic();
    test_two_loads();
    test_load_before_store();
    test_full();
    test_restore_blocked();
    test_abort();
    test_stall();
    test_err();
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
